// File: rtl/dom_pkg.sv
// Shared types and constants for the first-order DOM share generator.
// Holds the LFSR polynomial, default seed and the transaction phase encoding.
package dom_pkg;

    localparam int                LFSR_W       = 32;
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1_0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2
    } share_state_e;

    // Galois right-shift step for x^32+x^22+x^2+x+1.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
    endfunction

    // An all-zero state would lock the LFSR, so it is replaced by the fallback seed.
    function automatic logic [LFSR_W-1:0] seed_sanitize(
        input logic [LFSR_W-1:0] seed_data,
        input logic [LFSR_W-1:0] fallback
    );
        return (seed_data == '0) ? fallback : seed_data;
    endfunction

endpackage

// File: rtl/dom_lfsr32.sv
// Free-running 32-bit Galois LFSR that supplies masks and gadget randomness.
// A reseed request takes priority over stepping in the same cycle.
module dom_lfsr32
    import dom_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed_data,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (seed_valid) begin
            state <= seed_sanitize(seed_data, SEED);
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/dom_d1_share_gen.sv
// Splits unmasked operands into two Boolean shares each and supplies fresh randomness
// to a first-order DOM AND gadget, holding shares stable across its two-cycle window.
module dom_d1_share_gen
    import dom_pkg::*;
#(
    parameter int                WIDTH = 1,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 seed_valid,
    input  logic [LFSR_W-1:0]    seed_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [2*WIDTH-1:0]   share_a,
    output logic [2*WIDTH-1:0]   share_b,
    output logic [WIDTH-1:0]     rand_r,
    output logic                 out_valid,
    input  logic                 out_ready
);

    share_state_e       state;
    logic [LFSR_W-1:0]  lfsr;
    logic [WIDTH-1:0]   mask_a;
    logic [WIDTH-1:0]   mask_b;
    logic [WIDTH-1:0]   fresh_r;
    logic [2*WIDTH-1:0] next_share_a;
    logic [2*WIDTH-1:0] next_share_b;
    logic               accept;

    dom_lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .state      (lfsr)
    );

    // Disjoint LFSR slices, so masks and r in one transaction are independent bits.
    assign mask_a  = lfsr[WIDTH-1:0];
    assign mask_b  = lfsr[2*WIDTH-1:WIDTH];
    assign fresh_r = lfsr[3*WIDTH-1:2*WIDTH];

    if (3 * WIDTH < LFSR_W) begin : g_lfsr_hi
        logic unused_lfsr_hi;
        assign unused_lfsr_hi = ^lfsr[LFSR_W-1:3*WIDTH];
    end

    always_comb begin
        next_share_a = '0;
        next_share_b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            next_share_a[2*i]   = in_a[i] ^ mask_a[i];
            next_share_a[2*i+1] = mask_a[i];
            next_share_b[2*i]   = in_b[i] ^ mask_b[i];
            next_share_b[2*i+1] = mask_b[i];
        end
    end

    // In PH1 a new operand can only enter once the consumer has sampled c.
    assign in_ready = (state == IDLE) || ((state == PH1) && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            share_a   <= '0;
            share_b   <= '0;
            rand_r    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (accept) begin
                        share_a <= next_share_a;
                        share_b <= next_share_b;
                        rand_r  <= fresh_r;
                        state   <= PH0;
                    end else begin
                        share_a <= '0;
                        share_b <= '0;
                        rand_r  <= '0;
                    end
                end
                PH0: begin
                    out_valid <= 1'b1;
                    state     <= PH1;
                end
                PH1: begin
                    // Without out_ready everything holds, so the gadget reloads identical values.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            share_a <= next_share_a;
                            share_b <= next_share_b;
                            rand_r  <= fresh_r;
                            state   <= PH0;
                        end else begin
                            share_a <= '0;
                            share_b <= '0;
                            rand_r  <= '0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    share_a   <= '0;
                    share_b   <= '0;
                    rand_r    <= '0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
